soc_ram_dma: RTL



---
 rtl/soc_ram_dma.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/soc_ram_dma.sv
// Block-transfer engine mastering Port B of the SoC dual-port RAM.
// Write commands push a din stream into RAM; read commands stream RAM words out through a 2-entry FIFO.
module soc_ram_dma #(
  parameter int ADDR_MSB = 6,
  parameter int MEM_SIZE = 256
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_MSB:0]   cmd_addr,
  input  logic [ADDR_MSB+1:0] cmd_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [15:0]         din_data,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [15:0]         dout_data,
  output logic [ADDR_MSB:0]   soc_ram_addrb,
  output logic                soc_ram_cenb,
  output logic [1:0]          soc_ram_wenb,
  output logic [15:0]         soc_ram_dinb,
  input  logic [15:0]         soc_ram_doutb
);

  localparam int AW = ADDR_MSB + 1;
  localparam int LW = ADDR_MSB + 2;
  localparam int CW = ADDR_MSB + 3;
  localparam logic [CW-1:0] WORDS = CW'(MEM_SIZE / 2);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t        state;
  logic [AW-1:0] xfer_addr;
  logic [LW-1:0] xfer_cnt;
  logic [15:0]   fifo_mem [0:1];
  logic          fifo_wr;
  logic          fifo_rd;
  logic [1:0]    fifo_count;
  logic          inflight;

  logic          cmd_acc;
  logic          range_bad;
  logic          din_hs;
  logic          pop;
  logic          rd_issue;
  logic          rd_ok;
  logic [CW-1:0] cmd_end;
  logic [2:0]    outstanding;

  assign cmd_acc    = cmd_valid & cmd_ready;
  assign cmd_end    = {2'b00, cmd_addr} + {1'b0, cmd_len};
  assign range_bad  = cmd_end > WORDS;
  assign din_hs     = din_valid & din_ready;
  assign dout_valid = fifo_count != 2'd0;
  assign dout_data  = fifo_mem[fifo_rd];
  assign pop        = dout_valid & dout_ready;
  assign rd_issue   = ~soc_ram_cenb & (soc_ram_wenb == 2'b11);

  // A read holds a FIFO credit from issue until its word is popped, so the FIFO cannot overflow.
  assign outstanding = {1'b0, fifo_count} + {2'b00, inflight} + {2'b00, rd_issue} - {2'b00, pop};
  assign rd_ok       = outstanding < 3'd2;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      inflight    <= 1'b0;
      fifo_wr     <= 1'b0;
      fifo_rd     <= 1'b0;
      fifo_count  <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      inflight <= rd_issue;
      if (inflight) begin
        fifo_mem[fifo_wr] <= soc_ram_doutb;
        fifo_wr           <= ~fifo_wr;
      end
      if (pop) fifo_rd <= ~fifo_rd;
      case ({inflight, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      din_ready     <= 1'b0;
      xfer_addr     <= '0;
      xfer_cnt      <= '0;
      soc_ram_cenb  <= 1'b1;
      soc_ram_wenb  <= 2'b11;
      soc_ram_addrb <= '0;
      soc_ram_dinb  <= '0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      soc_ram_cenb <= 1'b1;
      soc_ram_wenb <= 2'b11;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_acc) begin
            if (range_bad) begin
              err <= 1'b1;
            end else if (cmd_len == '0) begin
              done <= 1'b1;
            end else if (cmd_write) begin
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              din_ready <= 1'b1;
              xfer_addr <= cmd_addr;
              xfer_cnt  <= cmd_len;
              state     <= WRITE;
            end else begin
              // The first read goes out straight from the accept edge.
              cmd_ready     <= 1'b0;
              busy          <= 1'b1;
              soc_ram_cenb  <= 1'b0;
              soc_ram_addrb <= cmd_addr;
              xfer_addr     <= cmd_addr + 1'b1;
              xfer_cnt      <= cmd_len - 1'b1;
              state         <= (cmd_len == LW'(1)) ? DRAIN : READ;
            end
          end
        end
        WRITE: begin
          if (din_hs) begin
            soc_ram_cenb  <= 1'b0;
            soc_ram_wenb  <= 2'b00;
            soc_ram_addrb <= xfer_addr;
            soc_ram_dinb  <= din_data;
            xfer_addr     <= xfer_addr + 1'b1;
            xfer_cnt      <= xfer_cnt - 1'b1;
            if (xfer_cnt == LW'(1)) begin
              din_ready <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        READ: begin
          if (rd_ok) begin
            soc_ram_cenb  <= 1'b0;
            soc_ram_addrb <= xfer_addr;
            xfer_addr     <= xfer_addr + 1'b1;
            xfer_cnt      <= xfer_cnt - 1'b1;
            if (xfer_cnt == LW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && fifo_count == 2'd1 && !inflight && !rd_issue) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
